// File: rtl/dtc_pkg.sv
// Shared types and constants for the DTC register-bus arbiter and its reply serializer.
package dtc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_REPLY
    } arb_state_t;

    localparam logic [7:0]  REPLY_HDR_DEFAULT = 8'hE1;
    localparam logic [31:0] ERR_WORD          = 32'hDEADBEEF;
    localparam int          REPLY_LEN         = 40;
    localparam int          REPLY_CNT_W       = $clog2(REPLY_LEN + 1);

endpackage

// File: rtl/dtc_reply_ser.sv
// 40-bit load/shift serializer for DTC read replies, MSB first, one bit per cycle.
module dtc_reply_ser
    import dtc_pkg::*;
(
    input  logic                 dtc_clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [REPLY_LEN-1:0] data,
    output logic                 busy,
    output logic                 bit_out,
    output logic                 last
);

    logic [REPLY_LEN-1:0]   shift_reg;
    logic [REPLY_CNT_W-1:0] cnt_reg;
    logic                   busy_reg;

    always_ff @(posedge dtc_clk) begin
        if (rst) begin
            shift_reg <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
        end else if (load) begin
            shift_reg <= data;
            cnt_reg   <= REPLY_CNT_W'(REPLY_LEN);
            busy_reg  <= 1'b1;
        end else if (busy_reg) begin
            // Zero-filling leaves bit_out low once the frame has drained.
            shift_reg <= {shift_reg[REPLY_LEN-2:0], 1'b0};
            cnt_reg   <= cnt_reg - REPLY_CNT_W'(1);
            if (cnt_reg == REPLY_CNT_W'(1)) begin
                busy_reg <= 1'b0;
            end
        end
    end

    assign busy    = busy_reg;
    assign bit_out = shift_reg[REPLY_LEN-1];
    assign last    = busy_reg && (cnt_reg == REPLY_CNT_W'(1));

endmodule

// File: rtl/dtc_reg_arbiter.sv
// Round-robin arbiter between DTC slow commands and a local requester on a shared register bus.
// Optional bus-ack timeout enabled by defining DTC_ARB_TIMEOUT_EN.
module dtc_reg_arbiter
    import dtc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [7:0]  REPLY_HDR      = REPLY_HDR_DEFAULT
) (
    input  logic        dtc_clk,
    input  logic        rst,
    input  logic        dtc_rd,
    input  logic        dtc_wr,
    input  logic [31:0] dtc_addr,
    input  logic [31:0] dtc_wdata,
    input  logic        loc_req,
    input  logic        loc_we,
    input  logic [31:0] loc_addr,
    input  logic [31:0] loc_wdata,
    output logic        loc_ack,
    output logic [31:0] loc_rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        reply_bit,
    output logic        reply_en,
    output logic        err_ovf,
    output logic        err_tmo
);

    arb_state_t  state_reg;
    logic        pend_valid_reg, pend_we_reg;
    logic [31:0] pend_addr_reg, pend_wdata_reg;
    logic        rr_loc_reg;
    logic        src_loc_reg;
    logic        bus_req_reg, bus_we_reg;
    logic [31:0] bus_addr_reg, bus_wdata_reg;
    logic        loc_ack_reg;
    logic [31:0] loc_rdata_reg;
    logic        err_ovf_reg;

    logic        dtc_pulse, dtc_cand, loc_cand, idle;
    logic        grant_dtc, grant_loc;
    logic        cand_we;
    logic [31:0] cand_addr, cand_wdata;
    logic        tmo_hit, done;
    logic [31:0] rdata_eff;
    logic        ser_load, ser_busy, ser_last;

    // A fresh pulse competes directly when nothing is pending, so it can win the same-cycle race.
    assign dtc_pulse  = dtc_rd | dtc_wr;
    assign dtc_cand   = pend_valid_reg | dtc_pulse;
    assign cand_we    = pend_valid_reg ? pend_we_reg    : dtc_wr;
    assign cand_addr  = pend_valid_reg ? pend_addr_reg  : dtc_addr;
    assign cand_wdata = pend_valid_reg ? pend_wdata_reg : dtc_wdata;
    // loc_req is still high during the loc_ack cycle; it must not be granted again.
    assign loc_cand   = loc_req & ~loc_ack_reg;
    assign idle       = (state_reg == ST_IDLE);
    assign grant_dtc  = idle & dtc_cand & (~loc_cand | ~rr_loc_reg);
    assign grant_loc  = idle & loc_cand & (~dtc_cand | rr_loc_reg);

`ifdef DTC_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt_reg;
    logic        err_tmo_reg;

    assign tmo_hit = (state_reg == ST_BUS) && !bus_ack
                     && (tmo_cnt_reg == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge dtc_clk) begin
        if (rst) begin
            tmo_cnt_reg <= '0;
            err_tmo_reg <= 1'b0;
        end else begin
            if (state_reg != ST_BUS) begin
                tmo_cnt_reg <= '0;
            end else if (!bus_ack) begin
                tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
            end
            if (tmo_hit) begin
                err_tmo_reg <= 1'b1;
            end
        end
    end

    assign err_tmo = err_tmo_reg;
`else
    assign tmo_hit = 1'b0;
    assign err_tmo = 1'b0;
`endif

    assign done      = (state_reg == ST_BUS) && (bus_ack || tmo_hit);
    assign rdata_eff = bus_ack ? bus_rdata : ERR_WORD;
    assign ser_load  = done && !src_loc_reg && !bus_we_reg;

    always_ff @(posedge dtc_clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            pend_valid_reg <= 1'b0;
            pend_we_reg    <= 1'b0;
            pend_addr_reg  <= '0;
            pend_wdata_reg <= '0;
            rr_loc_reg     <= 1'b0;
            src_loc_reg    <= 1'b0;
            bus_req_reg    <= 1'b0;
            bus_we_reg     <= 1'b0;
            bus_addr_reg   <= '0;
            bus_wdata_reg  <= '0;
            loc_ack_reg    <= 1'b0;
            loc_rdata_reg  <= '0;
            err_ovf_reg    <= 1'b0;
        end else begin
            loc_ack_reg <= 1'b0;

            if (grant_dtc) begin
                pend_valid_reg <= 1'b0;
            end
            if (dtc_pulse) begin
                if (pend_valid_reg && !grant_dtc) begin
                    err_ovf_reg <= 1'b1;
                end else if (pend_valid_reg || !grant_dtc) begin
                    pend_valid_reg <= 1'b1;
                    pend_we_reg    <= dtc_wr;
                    pend_addr_reg  <= dtc_addr;
                    pend_wdata_reg <= dtc_wdata;
                end
            end

            case (state_reg)
                ST_IDLE: begin
                    if (grant_dtc || grant_loc) begin
                        state_reg     <= ST_BUS;
                        bus_req_reg   <= 1'b1;
                        bus_we_reg    <= grant_dtc ? cand_we    : loc_we;
                        bus_addr_reg  <= grant_dtc ? cand_addr  : loc_addr;
                        bus_wdata_reg <= grant_dtc ? cand_wdata : loc_wdata;
                        src_loc_reg   <= grant_loc;
                        rr_loc_reg    <= grant_dtc;
                    end
                end
                ST_BUS: begin
                    if (done) begin
                        bus_req_reg <= 1'b0;
                        if (src_loc_reg) begin
                            loc_ack_reg   <= 1'b1;
                            loc_rdata_reg <= bus_we_reg ? 32'd0 : rdata_eff;
                            state_reg     <= ST_IDLE;
                        end else if (bus_we_reg) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            state_reg <= ST_REPLY;
                        end
                    end
                end
                ST_REPLY: begin
                    if (ser_last) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    dtc_reply_ser u_reply_ser (
        .dtc_clk (dtc_clk),
        .rst     (rst),
        .load    (ser_load),
        .data    ({REPLY_HDR, rdata_eff}),
        .busy    (ser_busy),
        .bit_out (reply_bit),
        .last    (ser_last)
    );

    assign reply_en  = ser_busy;
    assign loc_ack   = loc_ack_reg;
    assign loc_rdata = loc_rdata_reg;
    assign bus_req   = bus_req_reg;
    assign bus_we    = bus_we_reg;
    assign bus_addr  = bus_addr_reg;
    assign bus_wdata = bus_wdata_reg;
    assign err_ovf   = err_ovf_reg;

endmodule

// File: tb/tb_dtc_reg_arbiter.sv
// Directed self-checking bench for dtc_reg_arbiter; timeout checks depend on DTC_ARB_TIMEOUT_EN.
module tb_dtc_reg_arbiter;

    logic        dtc_clk = 1'b0;
    logic        rst = 1'b1;
    logic        dtc_rd = 1'b0, dtc_wr = 1'b0;
    logic [31:0] dtc_addr = '0, dtc_wdata = '0;
    logic        loc_req = 1'b0, loc_we = 1'b0;
    logic [31:0] loc_addr = '0, loc_wdata = '0;
    logic        loc_ack;
    logic [31:0] loc_rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        reply_bit, reply_en, err_ovf, err_tmo;

    int total = 0;
    int bad = 0;

    dtc_reg_arbiter #(.TIMEOUT_CYCLES(8), .REPLY_HDR(8'hE1)) dut (
        .dtc_clk(dtc_clk), .rst(rst),
        .dtc_rd(dtc_rd), .dtc_wr(dtc_wr), .dtc_addr(dtc_addr), .dtc_wdata(dtc_wdata),
        .loc_req(loc_req), .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
        .loc_ack(loc_ack), .loc_rdata(loc_rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .reply_bit(reply_bit), .reply_en(reply_en), .err_ovf(err_ovf), .err_tmo(err_tmo)
    );

    always #5 dtc_clk = ~dtc_clk;

    task automatic tick;
        @(posedge dtc_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic dtc_pulse(input logic we, input logic [31:0] a, input logic [31:0] d);
        dtc_wr = we; dtc_rd = ~we; dtc_addr = a; dtc_wdata = d;
        tick;
        dtc_wr = 1'b0; dtc_rd = 1'b0;
    endtask

    task automatic bus_complete(input logic [31:0] d);
        bus_ack = 1'b1; bus_rdata = d;
        tick;
        bus_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] cap;
        int          en_cnt;
        int          n;

        // Reset state
        tick; tick;
        chk("rst_bus_req", bus_req, 0);
        chk("rst_loc_ack", loc_ack, 0);
        chk("rst_reply_en", reply_en, 0);
        chk("rst_reply_bit", reply_bit, 0);
        chk("rst_err_ovf", err_ovf, 0);
        chk("rst_err_tmo", err_tmo, 0);
        rst = 1'b0;
        tick;

        // DTC write: single bus write, no reply, no local ack
        dtc_pulse(1'b1, 32'h10, 32'h1234);
        chk("wr_bus_req", bus_req, 1);
        chk("wr_bus_we", bus_we, 1);
        chk("wr_bus_addr", bus_addr, 32'h10);
        chk("wr_bus_wdata", bus_wdata, 32'h1234);
        tick; tick;
        chk("wr_bus_req_held", bus_req, 1);
        bus_complete(32'h0);
        chk("wr_bus_req_drop", bus_req, 0);
        chk("wr_no_reply", reply_en, 0);
        tick;
        chk("wr_no_loc_ack", loc_ack, 0);
        chk("wr_no_reply2", reply_en, 0);

        // DTC read: 40-bit reply E1 then A5A5A5A5
        dtc_pulse(1'b0, 32'h20, 32'h0);
        chk("rd_bus_we", bus_we, 0);
        chk("rd_bus_addr", bus_addr, 32'h20);
        tick; tick;
        bus_complete(32'hA5A5A5A5);
        cap = '0; en_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cap = {cap[38:0], reply_bit};
            en_cnt += int'(reply_en);
            tick;
        end
        chk("reply_bits", cap, 40'hE1A5A5A5A5);
        chk("reply_en_cycles", en_cnt, 40);
        chk("reply_en_off", reply_en, 0);
        chk("rd_no_loc_ack", loc_ack, 0);

        // Round robin after reset: DTC first, then local; two locals back to back
        rst = 1'b1; tick; rst = 1'b0;
        loc_req = 1'b1; loc_we = 1'b1; loc_addr = 32'h30; loc_wdata = 32'h55;
        dtc_pulse(1'b1, 32'h40, 32'h66);
        chk("rr_first_dtc", bus_addr, 32'h40);
        bus_complete(32'h0);
        tick;
        chk("rr_second_loc_addr", bus_addr, 32'h30);
        chk("rr_second_loc_req", bus_req, 1);
        bus_complete(32'hFFFF0000);
        chk("loc_wr_ack", loc_ack, 1);
        chk("loc_wr_rdata", loc_rdata, 32'h0);
        loc_we = 1'b0; loc_addr = 32'h34;
        tick;
        chk("loc_ack_pulse", loc_ack, 0);
        tick;
        chk("loc2_bus_addr", bus_addr, 32'h34);
        chk("loc2_bus_we", bus_we, 0);
        bus_complete(32'hCAFEF00D);
        chk("loc2_ack", loc_ack, 1);
        chk("loc2_rdata", loc_rdata, 32'hCAFEF00D);
        loc_req = 1'b0;
        tick;
        chk("loc2_ack_drop", loc_ack, 0);
        chk("loc2_no_regrant", bus_req, 0);

        // Three DTC writes during a stalled access: exec, pending, dropped
        dtc_pulse(1'b1, 32'h100, 32'h1);
        dtc_pulse(1'b1, 32'h104, 32'h2);
        chk("ovf_not_yet", err_ovf, 0);
        dtc_pulse(1'b1, 32'h108, 32'h3);
        chk("ovf_set", err_ovf, 1);
        chk("ovf_first_addr", bus_addr, 32'h100);
        bus_complete(32'h0);
        tick;
        chk("ovf_second_addr", bus_addr, 32'h104);
        chk("ovf_second_data", bus_wdata, 32'h2);
        bus_complete(32'h0);
        tick;
        chk("ovf_third_dropped", bus_req, 0);
        chk("ovf_sticky", err_ovf, 1);

        // Local read with no bus_ack
        loc_req = 1'b1; loc_we = 1'b0; loc_addr = 32'h200;
        tick;
        chk("tmo_bus_req", bus_req, 1);
`ifdef DTC_ARB_TIMEOUT_EN
        n = 0;
        while (!loc_ack && n < 30) begin
            tick;
            n++;
        end
        chk("tmo_latency", n, 8);
        chk("tmo_rdata", loc_rdata, 32'hDEADBEEF);
        chk("tmo_err", err_tmo, 1);
        loc_req = 1'b0;
        tick;
        chk("tmo_bus_req_drop", bus_req, 0);
`else
        n = 0;
        while (!loc_ack && n < 20) begin
            tick;
            n++;
        end
        chk("notmo_waiting", bus_req, 1);
        chk("notmo_no_ack", loc_ack, 0);
        chk("notmo_err_tied", err_tmo, 0);
        bus_complete(32'h77);
        chk("notmo_ack", loc_ack, 1);
        chk("notmo_rdata", loc_rdata, 32'h77);
        loc_req = 1'b0;
        tick;
`endif

        // Reset at reply bit 10 aborts the reply
        dtc_pulse(1'b0, 32'h300, 32'h0);
        bus_complete(32'h12345678);
        chk("rst_reply_started", reply_en, 1);
        for (int i = 0; i < 10; i++) tick;
        chk("rst_reply_bit10_en", reply_en, 1);
        rst = 1'b1; tick; rst = 1'b0;
        chk("rst_reply_en_low", reply_en, 0);
        chk("rst_reply_bus_req", bus_req, 0);
        chk("rst_err_ovf_clr", err_ovf, 0);
        dtc_pulse(1'b1, 32'h400, 32'h9);
        chk("post_rst_bus_addr", bus_addr, 32'h400);
        bus_complete(32'h0);
        chk("post_rst_done", bus_req, 0);
        chk("post_rst_no_reply", reply_en, 0);

        // Reset coinciding with bus_ack of a local read: no loc_ack
        loc_req = 1'b1; loc_we = 1'b0; loc_addr = 32'h500;
        tick;
        bus_ack = 1'b1; bus_rdata = 32'h1111; rst = 1'b1;
        tick;
        bus_ack = 1'b0; rst = 1'b0; loc_req = 1'b0;
        chk("rst_abort_no_ack", loc_ack, 0);
        chk("rst_abort_bus_req", bus_req, 0);
        tick;
        chk("rst_abort_no_ack2", loc_ack, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
